// File: rtl/key_schedule_pkg.sv
// Shared AES key-schedule types: sequencer states, sizes, round-key type.
// Imported by key_schedule and key_store.
package key_schedule_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_NK_W = 128;
    localparam int RK_DEPTH = AES_NR + 1;
    localparam int RK_AW    = 4;

    // Highest valid round-key index (key 10).
    localparam logic [RK_AW-1:0] RK_LAST = RK_AW'(RK_DEPTH - 1);

    typedef logic [AES_NK_W-1:0] rkey_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } ks_state_t;

    function automatic logic addr_ok(input logic [RK_AW-1:0] a);
        return a <= RK_LAST;
    endfunction

endpackage

// File: rtl/key_store.sv
// 11 x 128 round-key register file: one write port, one registered read.
// Ports: clk, rst (async, low), we/waddr/wdata, rd_en/rd_ok/rd_addr,
//        rd_data/rd_valid (valid only when rd_ok and address in range).
module key_store
    import key_schedule_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RK_AW-1:0] waddr,
    input  rkey_t            wdata,
    input  logic             rd_en,
    input  logic             rd_ok,
    input  logic [RK_AW-1:0] rd_addr,
    output rkey_t            rd_data,
    output logic             rd_valid
);

    // Storage is not reset; rd_ok (keys_ready) gates visibility.
    rkey_t mem [RK_DEPTH];

    logic rd_hit;

    assign rd_hit = rd_ok && addr_ok(rd_addr);

    always_ff @(posedge clk) begin
        if (we && addr_ok(waddr)) begin
            mem[waddr] <= wdata;
        end
    end

    // rd_data holds when no read is requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (rd_en) begin
            if (rd_hit) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_addr];
            end else begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/key_schedule.sv
// AES-128 key-schedule sequencer: drives key_expand once per round,
// stores keys 0..10 in key_store and serves them through a read port.
// Ports: clk, rst (async, low), start/key_in, busy/done/err/keys_ready,
//        rd_en/rd_addr -> rd_data/rd_valid,
//        ke_valid/ke_round/ke_key -> key_expand -> ke_out_valid/ke_key_out.
// Only NR=10 is meaningful; TIMEOUT bounds a WAIT (2..255 cycles).
module key_schedule
    import key_schedule_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         keys_ready,
    input  logic         rd_en,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    output logic         ke_valid,
    output logic [3:0]   ke_round,
    output logic [127:0] ke_key,
    input  logic         ke_out_valid,
    input  logic [127:0] ke_key_out
);

    localparam logic [3:0] RND_LAST = 4'(NR - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    ks_state_t state_q;
    ks_state_t state_d;

    rkey_t      key_reg;
    logic [3:0] round_q;
    logic [7:0] tmo_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       ready_q;

    logic       st_load;
    logic       st_cap;
    logic       tmo_clr;
    logic       tmo_inc;
    logic       tmo_hit;
    logic       last_rnd;

    logic       st_we;
    logic [3:0] st_waddr;
    rkey_t      st_wdata;

    assign last_rnd = (round_q == RND_LAST);

    always_comb begin
        state_d = state_q;
        st_load = 1'b0;
        st_cap  = 1'b0;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_load = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                tmo_clr = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ke_out_valid) begin
                    st_cap  = 1'b1;
                    state_d = last_rnd ? S_DONE : S_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    // TIMEOUT idle WAIT cycles have elapsed.
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            key_reg <= '0;
            round_q <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= st_cap && last_rnd;
            err_q   <= tmo_hit;
            if (st_load) begin
                key_reg <= key_in;
                round_q <= '0;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 8'd1;
            end
            if (st_cap) begin
                key_reg <= ke_key_out;
                if (!last_rnd) begin
                    round_q <= round_q + 4'd1;
                end
            end
            if (tmo_hit) begin
                busy_q <= 1'b0;
            end
            if (state_q == S_DONE) begin
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    // Key 0 is the cipher key itself; key r+1 comes from round r.
    assign st_we    = st_load | st_cap;
    assign st_waddr = st_load ? 4'd0 : round_q + 4'd1;
    assign st_wdata = st_load ? key_in : ke_key_out;

    key_store u_store (
        .clk      (clk),
        .rst      (rst),
        .we       (st_we),
        .waddr    (st_waddr),
        .wdata    (st_wdata),
        .rd_en    (rd_en),
        .rd_ok    (ready_q),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign keys_ready = ready_q;
    assign ke_valid   = (state_q == S_REQ);
    assign ke_round   = round_q;
    assign ke_key     = key_reg;

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule with a behavioural key_expand
// of configurable latency and a read-port scoreboard.
module tb_key_schedule;

    localparam int TMO = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic         keys_ready;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         ke_valid;
    logic [3:0]   ke_round;
    logic [127:0] ke_key;
    logic         ke_out_valid;
    logic [127:0] ke_key_out;

    key_schedule #(.NR(10), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .keys_ready   (keys_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .ke_valid     (ke_valid),
        .ke_round     (ke_round),
        .ke_key       (ke_key),
        .ke_out_valid (ke_out_valid),
        .ke_key_out   (ke_key_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gmul(a, 8'(b)) == 8'h01) v = 8'(b);
            end
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd0: c = 8'h01;
            4'd1: c = 8'h02;
            4'd2: c = 8'h04;
            4'd3: c = 8'h08;
            4'd4: c = 8'h10;
            4'd5: c = 8'h20;
            4'd6: c = 8'h40;
            4'd7: c = 8'h80;
            4'd8: c = 8'h1b;
            4'd9: c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] k,
                                              input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]),
              sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rcon(r), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [127:0] exp_k [11];

    task automatic compute(input logic [127:0] k);
        exp_k[0] = k;
        for (int i = 1; i < 11; i++) begin
            exp_k[i] = round_fn(exp_k[i-1], 4'(i - 1));
        end
    endtask

    // ---------------- key_expand model ----------------
    int           lat  = 1;
    bit           mute = 1'b0;
    int           m_cnt;
    logic [127:0] m_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0;
            m_res <= '0;
        end else if (ke_valid) begin
            m_res <= round_fn(ke_key, ke_round);
            m_cnt <= lat;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign ke_out_valid = !mute && (m_cnt == 1);
    assign ke_key_out   = m_res;

    logic [3:0] rlog [$];

    always @(posedge clk) begin
        if (rst && ke_valid) rlog.push_back(ke_round);
    end

    // ---------------- read scoreboard ----------------
    typedef struct {
        logic         v;
        logic [127:0] d;
    } rd_exp_t;

    rd_exp_t      sbq [$];
    logic [127:0] last_d = '0;

    task automatic rd(input logic [3:0] a, input logic v,
                      input logic [127:0] d);
        rd_exp_t e;
        e.v = v;
        e.d = d;
        rd_en   = 1'b1;
        rd_addr = a;
        sbq.push_back(e);
    endtask

    task automatic tick();
        rd_exp_t e;
        logic    p;
        p = rd_en;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (p) begin
            if (sbq.size() == 0) begin
                chk("sb_empty", 128'(1), 128'(0));
            end else begin
                e = sbq.pop_front();
                chk("rd_valid", 128'(rd_valid), 128'(e.v));
                chk("rd_data", rd_data, e.d);
                last_d = e.d;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_ready"}, 128'(keys_ready), 128'(0));
        chk({tag, "_rdv"}, 128'(rd_valid), 128'(0));
        chk({tag, "_rdd"}, rd_data, 128'(0));
        chk({tag, "_kev"}, 128'(ke_valid), 128'(0));
        chk({tag, "_ker"}, 128'(ke_round), 128'(0));
        chk({tag, "_kek"}, ke_key, 128'(0));
    endtask

    task automatic chk_rlog(input string tag);
        chk({tag, "_rlog_n"}, 128'(rlog.size()), 128'(10));
        for (int i = 0; i < rlog.size() && i < 10; i++) begin
            chk({tag, "_rlog"}, 128'(rlog[i]), 128'(i));
        end
    endtask

    // Start cycle is cycle 1; returns cycle numbers of done/err/ke_valid.
    task automatic run(input logic [127:0] k, input bit hold,
                       output int done_c, output int err_c,
                       output int kv_c);
        done_c = 0;
        err_c  = 0;
        kv_c   = 0;
        rlog.delete();
        key_in = k;
        start  = 1'b1;
        for (int c = 2; c <= 200; c++) begin
            if (c == 4) rd(4'd3, 1'b0, '0);
            tick();
            if (!hold) start = 1'b0;
            if (c == 2) chk("busy_up", 128'(busy), 128'(1));
            if (ke_valid && kv_c == 0) kv_c = c;
            if (done) begin
                done_c = c;
                break;
            end
            if (err) begin
                err_c = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic after_done(input string tag);
        chk({tag, "_rdy_in_done"}, 128'(keys_ready), 128'(0));
        rd(4'd10, 1'b0, '0);
        tick();
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
        chk({tag, "_rdy"}, 128'(keys_ready), 128'(1));
        chk({tag, "_busy_dn"}, 128'(busy), 128'(0));
        rd(4'd10, 1'b1, exp_k[10]);
        tick();
    endtask

    typedef struct {
        logic [3:0]   a;
        logic         v;
        logic [127:0] d;
    } vec_t;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        vec_t vt [7];
        int   dc, ec, kc;
        bit   found;

        rst     = 1'b0;
        start   = 1'b0;
        key_in  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;

        compute(KEY_A);
        vt[0] = '{4'd0,  1'b1, KEY_A};
        vt[1] = '{4'd1,  1'b1, A_K1};
        vt[2] = '{4'd10, 1'b1, A_K10};
        vt[3] = '{4'd11, 1'b0, 128'h0};
        vt[4] = '{4'd15, 1'b0, 128'h0};
        vt[5] = '{4'd4,  1'b1, exp_k[4]};
        vt[6] = '{4'd9,  1'b1, exp_k[9]};

        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Nominal schedule, L=1.
        run(KEY_A, 1'b0, dc, ec, kc);
        chk("a_done_cyc", 128'(dc), 128'(22));
        chk_rlog("a");
        after_done("a");
        for (int i = 0; i < 7; i++) begin
            rd(vt[i].a, vt[i].v, vt[i].d);
            tick();
        end
        tick();
        chk("hold_rdv", 128'(rd_valid), 128'(0));
        chk("hold_rdd", rd_data, last_d);

        // No key_expand response: timeout abort.
        mute = 1'b1;
        run(KEY_A, 1'b0, dc, ec, kc);
        chk("t_kv_cyc", 128'(kc), 128'(2));
        chk("t_err_cyc", 128'(ec), 128'(kc + TMO + 1));
        chk("t_busy", 128'(busy), 128'(0));
        chk("t_ready", 128'(keys_ready), 128'(0));
        rd(4'd0, 1'b0, '0);
        tick();
        chk("t_err_pulse", 128'(err), 128'(0));
        mute = 1'b0;
        repeat (3) tick();

        // start held high during generation.
        run(KEY_A, 1'b1, dc, ec, kc);
        chk("h_done_cyc", 128'(dc), 128'(22));
        chk_rlog("h");
        after_done("h");
        repeat (3) tick();
        chk("h_idle_kev", 128'(ke_valid), 128'(0));

        // Asynchronous reset during round 5.
        key_in = KEY_A;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ke_valid && ke_round == 4'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("r_found_r5", 128'(found), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk_reset("mid");
        last_d = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compute(KEY_B);
        run(KEY_B, 1'b0, dc, ec, kc);
        chk("b_done_cyc", 128'(dc), 128'(22));
        chk("b_ref_k10", exp_k[10], B_K10);
        after_done("b");
        rd(4'd10, 1'b1, B_K10);
        tick();
        rd(4'd5, 1'b1, exp_k[5]);
        tick();

        // key_expand latency 3.
        lat = 3;
        compute(KEY_A);
        run(KEY_A, 1'b0, dc, ec, kc);
        chk("l3_done_cyc", 128'(dc), 128'(42));
        chk_rlog("l3");
        after_done("l3");
        rd(4'd10, 1'b1, A_K10);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
Sequencer that drives the single-round key_expand stage ten times to build the full AES-128 round-key schedule (keys 0..10), then serves those keys to the cipher datapath through a registered read port. It sits directly upstream of key_expand: it supplies key_expand's key_in, round and valid, and captures key_out on out_valid. It exposes the key_expand hookup as ports so the top level wires the existing instance.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported.
TIMEOUT, 16, max cycles WAIT may last without ke_out_valid before abort; range 2..255.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin schedule generation from key_in; sampled in IDLE only
key_in  in  128  cipher key, sampled on accepted start
busy  out  1  high from accepted start until done/err
done  out  1  one-cycle pulse: all 11 keys stored
err  out  1  one-cycle pulse: timeout abort
keys_ready  out  1  level: stored schedule is valid
rd_en  in  1  read request
rd_addr  in  4  round-key index 0..10
rd_data  out  128  round key, one cycle after rd_en
rd_valid  out  1  qualifies rd_data
ke_valid  out  1  to key_expand valid
ke_round  out  4  to key_expand round (r-1 index: 0 produces key 1)
ke_key  out  128  to key_expand key_in; held stable through REQ and WAIT
ke_out_valid  in  1  from key_expand out_valid
ke_key_out  in  128  from key_expand key_out

Behaviour:
- One clock, clk. rst is asynchronous, active-low.
- Reset values: busy=0, done=0, err=0, keys_ready=0, rd_valid=0, rd_data=0, ke_valid=0, ke_round=0, ke_key=0, state=IDLE, round cnt=0, timeout cnt=0. Key storage is not reset; keys_ready gates it.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start=1 -> key_reg<=key_in, store[0]<=key_in, round<=0, keys_ready<=0, busy<=1, go to REQ.
- REQ: ke_valid=1 for exactly one cycle, ke_round=round, ke_key=key_reg. Timeout cnt<=0. Go to WAIT.
- WAIT: ke_valid=0, ke_key held.
  - ke_out_valid=1 -> store[round+1]<=ke_key_out, key_reg<=ke_key_out. If round==NR-1, go to DONE; else round<=round+1 and go to REQ.
  - Else timeout cnt++. At TIMEOUT: err pulse, busy<=0, keys_ready stays 0, go to IDLE.
- DONE: done=1 for one cycle, keys_ready<=1, busy<=0, go to IDLE.
- ke_out_valid outside WAIT is ignored.
- start while busy is ignored; no queuing.
- start in IDLE with keys_ready=1 clears keys_ready the next cycle and regenerates the schedule.
- Latency: with key_expand latency L (out_valid L cycles after valid), start-to-done = 1 + 10*(1+L) + 1 cycles. L=1 gives 22.
- Read port: rd_data/rd_valid are registered.
  - rd_en=1, keys_ready=1, rd_addr<=10 -> next cycle rd_valid=1, rd_data=store[rd_addr].
  - rd_addr 11..15, or keys_ready=0 -> next cycle rd_valid=0, rd_data=0.
  - rd_en=0 -> rd_valid=0 and rd_data holds.
- Reads in the DONE cycle are invalid (keys_ready not yet 1).
- Reset mid-generation: immediate return to reset values; the next start rebuilds from scratch.

Decomposition:
- Shared aes package:
  - state enum (IDLE/REQ/WAIT/DONE)
  - AES_NR=10, AES_NK_W=128, RK_DEPTH=11
  - round-key typedef logic [127:0]
- Sub-module key_store: 11x128 register file with one write port and one registered read port, including the address-range check. The FSM stays in key_schedule.

Test Plan:
- Bench uses a key_expand model with L=1. key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done at cycle 22. Reads must return:
  - addr0: 2b7e151628aed2a6abf7158809cf4f3c
  - addr1: a0fafe1788542cb123a339392a6c7605
  - addr10: d014f9a8c9ee2589e13f0cc8b6630ca6
- Model ke_out_valid never asserted -> err pulse exactly TIMEOUT+1 cycles after ke_valid; busy=0; keys_ready=0; reads give rd_valid=0.
- start re-asserted every cycle while busy -> exactly one schedule generated; ke_round sequence 0..9, each issued once.
- rst low during round 5 -> all outputs at reset values asynchronously. A new start with key 000102..0f yields addr10=13111d7fe3944a17f307a78b4d2b30c5.
- rd_en with rd_addr=11, and with addr=3 while busy -> rd_valid=0, rd_data=0. rd_en in the cycle after done with addr=10 -> valid key.
- Model with L=3 -> done at cycle 1+10*4+1=42; same addr10 key as the first scenario.
